// File: rtl/math_iq_pkg.sv
// Shared widths, entry/issue-word layouts and the issue-word packing helper
// for the math issue queue.
package math_iq_pkg;

  localparam int PREG_W  = 6;
  localparam int ROB_W   = 5;
  localparam int ISSUE_W = 18;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              r1;
    logic [PREG_W-1:0] rs2;
    logic              r2;
  } iq_entry_t;

  typedef struct packed {
    logic [PREG_W-1:0] rs2;
    logic [PREG_W-1:0] rs1;
    logic              rsv;
    logic [ROB_W-1:0]  rob;
  } issue_word_t;

  function automatic issue_word_t make_issue_word(input iq_entry_t e);
    issue_word_t w;
    w.rs2 = e.rs2;
    w.rs1 = e.rs1;
    w.rsv = 1'b0;
    w.rob = e.rob;
    return w;
  endfunction

endpackage

// File: rtl/math_iq_select.sv
// Find-first-set over the queue ready vector: the lowest set index is the
// oldest ready entry. Purely combinational.
module math_iq_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic w_seen;

  always_comb begin
    w_seen  = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i] & ~w_seen;
      if (o_grant[i]) begin
        o_idx = IDX_W'(i);
      end
      w_seen = w_seen | i_ready[i];
    end
  end

  assign o_any = |i_ready;

endmodule

// File: rtl/math_issue_queue.sv
// Collapsing oldest-first issue queue for the math pipe. Optional stall
// counter port perf_stall_o is built when MATH_IQ_PERF_EN is defined.
module math_issue_queue
  import math_iq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WK_PORTS = 3
) (
  input  logic                       cpu_clock_i,
  input  logic                       cpu_reset_n_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [ROB_W-1:0]           enq_rob_i,
  input  logic [PREG_W-1:0]          enq_rs1_i,
  input  logic                       enq_rs1_rdy_i,
  input  logic [PREG_W-1:0]          enq_rs2_i,
  input  logic                       enq_rs2_rdy_i,
  input  logic [WK_PORTS-1:0]        wk_valid_i,
  input  logic [PREG_W*WK_PORTS-1:0] wk_preg_i,
  output logic [ISSUE_W-1:0]         issue_data_o,
  output logic                       issue_valid_o
`ifdef MATH_IQ_PERF_EN
  ,
  output logic [31:0]                perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  iq_entry_t        r_q [DEPTH];
  iq_entry_t        w_woke [DEPTH];
  iq_entry_t        w_q_next [DEPTH];
  iq_entry_t        w_enq_entry;
  iq_entry_t        w_sel_entry;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_wr_idx;
  logic             r_enq_ready;
  logic             r_issue_valid;
  issue_word_t      r_issue_data;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_grant;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_any;
  logic             w_enq_fire;

  // Preg 0 is hard-wired ready; otherwise any strobed port naming the preg wakes it.
  function automatic logic f_woken(input logic [PREG_W-1:0]          preg,
                                   input logic [WK_PORTS-1:0]        wk_v,
                                   input logic [PREG_W*WK_PORTS-1:0] wk_p);
    logic hit;
    hit = (preg == '0);
    for (int p = 0; p < WK_PORTS; p++) begin
      if (wk_v[p] && (wk_p[PREG_W*p +: PREG_W] == preg)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
      assign w_ready[gi] = r_q[gi].valid & r_q[gi].r1 & r_q[gi].r2;
    end
  endgenerate

  math_iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .i_ready (w_ready),
    .o_grant (w_grant),
    .o_idx   (w_sel_idx),
    .o_any   (w_sel_any)
  );

  always_comb begin
    w_sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_entry = r_q[i];
      end
    end
  end

  assign w_enq_fire = enq_valid_i & r_enq_ready;
  assign w_wr_idx   = w_sel_any ? (r_count - CNT_ONE) : r_count;

  always_comb begin
    w_enq_entry.valid = 1'b1;
    w_enq_entry.rob   = enq_rob_i;
    w_enq_entry.rs1   = enq_rs1_i;
    w_enq_entry.r1    = enq_rs1_rdy_i | f_woken(enq_rs1_i, wk_valid_i, wk_preg_i);
    w_enq_entry.rs2   = enq_rs2_i;
    w_enq_entry.r2    = enq_rs2_rdy_i | f_woken(enq_rs2_i, wk_valid_i, wk_preg_i);
  end

  // Wake, then collapse over the issued slot, then drop the new uop into the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i]    = r_q[i];
      w_woke[i].r1 = r_q[i].r1 | f_woken(r_q[i].rs1, wk_valid_i, wk_preg_i);
      w_woke[i].r2 = r_q[i].r2 | f_woken(r_q[i].rs2, wk_valid_i, wk_preg_i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_q_next[i] = w_woke[i];
    end
    if (w_sel_any) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(w_sel_idx)) begin
          w_q_next[i] = w_woke[i+1];
        end
      end
      w_q_next[DEPTH-1] = '0;
    end
    if (w_enq_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == w_wr_idx) begin
          w_q_next[i] = w_enq_entry;
        end
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_enq_fire && !w_sel_any) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_enq_fire && w_sel_any) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count       <= '0;
      r_enq_ready   <= 1'b1;
      r_issue_valid <= 1'b0;
      r_issue_data  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count       <= '0;
      r_enq_ready   <= 1'b1;
      r_issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_q_next[i];
      end
      r_count       <= w_count_next;
      r_enq_ready   <= (w_count_next != CNT_FULL);
      r_issue_valid <= w_sel_any;
      if (w_sel_any) begin
        r_issue_data <= make_issue_word(w_sel_entry);
      end
    end
  end

  assign enq_ready_o   = r_enq_ready;
  assign issue_valid_o = r_issue_valid;
  assign issue_data_o  = r_issue_data;

`ifdef MATH_IQ_PERF_EN
  logic [31:0] r_perf_stall;

  // Flush deliberately does not clear this: it measures stalls across flushes.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_n_i) begin
      r_perf_stall <= '0;
    end else if ((r_count != '0) && !w_sel_any && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_math_issue_queue.sv
// Directed bench for math_issue_queue: an in-order uop-list model checked every
// cycle, plus literal expectations for the issue order and issue words.
module tb_math_issue_queue;

  localparam int DEPTH    = 8;
  localparam int WK_PORTS = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic                    enq_valid = 1'b0;
  logic                    enq_ready;
  logic [4:0]              enq_rob = '0;
  logic [5:0]              enq_rs1 = '0;
  logic                    enq_rs1_rdy = 1'b0;
  logic [5:0]              enq_rs2 = '0;
  logic                    enq_rs2_rdy = 1'b0;
  logic [WK_PORTS-1:0]     wk_valid = '0;
  logic [6*WK_PORTS-1:0]   wk_preg = '0;
  logic [17:0]             issue_data;
  logic                    issue_valid;
`ifdef MATH_IQ_PERF_EN
  logic [31:0]             perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;
  logic [4:0] issued [$];

  always #5 clk = ~clk;

  math_issue_queue #(.DEPTH(DEPTH), .WK_PORTS(WK_PORTS)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_n_i (rst_n),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_ready_o   (enq_ready),
    .enq_rob_i     (enq_rob),
    .enq_rs1_i     (enq_rs1),
    .enq_rs1_rdy_i (enq_rs1_rdy),
    .enq_rs2_i     (enq_rs2),
    .enq_rs2_rdy_i (enq_rs2_rdy),
    .wk_valid_i    (wk_valid),
    .wk_preg_i     (wk_preg),
    .issue_data_o  (issue_data),
    .issue_valid_o (issue_valid)
`ifdef MATH_IQ_PERF_EN
    ,
    .perf_stall_o  (perf_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: ordered list of waiting uops ----------------
  typedef struct {
    logic [4:0] rob;
    logic [5:0] rs1;
    logic       r1;
    logic [5:0] rs2;
    logic       r2;
  } uop_t;

  uop_t        mq [$];
  logic        m_iv;
  logic [17:0] m_id;
  logic        m_rdy;
  logic [31:0] m_perf;

  function automatic logic woken(input logic [5:0] preg, input logic [WK_PORTS-1:0] v,
                                 input logic [6*WK_PORTS-1:0] pr);
    logic h;
    h = (preg == 6'd0);
    for (int p = 0; p < WK_PORTS; p++)
      if (v[p] && pr[6*p +: 6] == preg) h = 1'b1;
    return h;
  endfunction

  always @(posedge clk) begin
    int   sel;
    bit   acc;
    uop_t u;
    sel = -1;
    for (int k = 0; k < mq.size(); k++)
      if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
    if (!rst_n) begin
      mq.delete();
      m_iv = 1'b0; m_id = '0; m_rdy = 1'b1; m_perf = '0;
    end else begin
      if (mq.size() != 0 && sel < 0 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (flush) begin
        mq.delete();
        m_iv = 1'b0; m_rdy = 1'b1;
      end else begin
        acc = enq_valid && m_rdy;
        if (sel >= 0) begin
          m_iv = 1'b1;
          m_id = {mq[sel].rs2, mq[sel].rs1, 1'b0, mq[sel].rob};
          mq.delete(sel);
        end else begin
          m_iv = 1'b0;
        end
        for (int k = 0; k < mq.size(); k++) begin
          u = mq[k];
          u.r1 = u.r1 | woken(u.rs1, wk_valid, wk_preg);
          u.r2 = u.r2 | woken(u.rs2, wk_valid, wk_preg);
          mq[k] = u;
        end
        if (acc) begin
          u.rob = enq_rob;
          u.rs1 = enq_rs1;
          u.r1  = enq_rs1_rdy | woken(enq_rs1, wk_valid, wk_preg);
          u.rs2 = enq_rs2;
          u.r2  = enq_rs2_rdy | woken(enq_rs2, wk_valid, wk_preg);
          mq.push_back(u);
        end
        m_rdy = (mq.size() != DEPTH);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("issue_valid", 32'(issue_valid), 32'(m_iv));
      check("issue_data", 32'(issue_data), 32'(m_id));
      check("enq_ready", 32'(enq_ready), 32'(m_rdy));
`ifdef MATH_IQ_PERF_EN
      check("perf_stall", perf_stall, m_perf);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (issue_valid) issued.push_back(issue_data[4:0]);
    $display("cycle t=%0t enq_v=%0b rdy=%0b issue_v=%0b data=%05h", $time, enq_valid, enq_ready,
             issue_valid, issue_data);
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    wk_valid  = '0;
    flush     = 1'b0;
  endtask

  task automatic do_enq(input int rob, input int rs1, input bit r1, input int rs2, input bit r2);
    enq_valid   = 1'b1;
    enq_rob     = 5'(rob);
    enq_rs1     = 6'(rs1);
    enq_rs1_rdy = r1;
    enq_rs2     = 6'(rs2);
    enq_rs2_rdy = r2;
  endtask

  // A negative preg leaves that port idle.
  task automatic wake(input int a, input int b, input int c);
    wk_valid = {c >= 0, b >= 0, a >= 0};
    wk_preg  = {6'(c < 0 ? 0 : c), 6'(b < 0 ? 0 : b), 6'(a < 0 ? 0 : a)};
  endtask

  task automatic check_issued(input string name, input int exp [$]);
    check({name, "_count"}, 32'(issued.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < issued.size(); k++)
      check(name, 32'(issued[k]), 32'(exp[k]));
  endtask

  initial begin
    // Reset
    idle();
    rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset_valid", 32'(issue_valid), 32'd0);
    check("reset_data", 32'(issue_data), 32'd0);
    check("reset_ready", 32'(enq_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: ready uop issues two cycles after enqueue
    do_enq(3, 5, 1, 0, 1);
    tick();
    idle();
    check("t1_not_yet", 32'(issue_valid), 32'd0);
    tick();
    check("t1_valid", 32'(issue_valid), 32'd1);
    check("t1_data", 32'(issue_data), 32'h00143);
    tick();
    check("t1_done", 32'(issue_valid), 32'd0);

    // 2: younger ready uop passes an older waiting one
    do_enq(1, 9, 0, 0, 1);
    tick();
    do_enq(2, 3, 1, 4, 1);
    tick();
    idle();
    tick();
    check("t2_first_rob2", 32'(issue_data), 32'h040C2);
    wake(-1, -1, 9);
    tick();
    idle();
    check("t2_gap", 32'(issue_valid), 32'd0);
    tick();
    check("t2_rob1_valid", 32'(issue_valid), 32'd1);
    check("t2_rob1_data", 32'(issue_data), 32'h00241);
    tick();

    // 3: wakeup coincident with enqueue
    do_enq(4, 12, 0, 0, 1);
    wake(-1, 12, -1);
    tick();
    idle();
    tick();
    check("t3_valid", 32'(issue_valid), 32'd1);
    check("t3_data", 32'(issue_data), 32'h00304);
    tick();

    // 4: fill, reject while full, wake and drain in age order
    issued.delete();
    for (int k = 0; k < DEPTH; k++) begin
      do_enq(8 + k, 20 + k, 0, 0, 0);
      tick();
    end
    idle();
    check("t4_full", 32'(enq_ready), 32'd0);
    do_enq(31, 1, 1, 0, 1);
    tick();
    tick();
    idle();
    check("t4_still_full", 32'(enq_ready), 32'd0);
    wake(20, 21, 22);
    tick();
    wake(23, 24, 25);
    tick();
    wake(26, 27, -1);
    tick();
    idle();
    repeat (10) tick();
    check_issued("t4_order", '{8, 9, 10, 11, 12, 13, 14, 15});
    check("t4_ready_back", 32'(enq_ready), 32'd1);

    // 5: issue from the middle with a simultaneous enqueue
    issued.delete();
    do_enq(16, 30, 0, 5, 1);
    tick();
    do_enq(17, 3, 1, 6, 1);
    tick();
    do_enq(18, 31, 0, 7, 1);
    tick();
    do_enq(19, 32, 0, 8, 1);
    tick();
    idle();
    wake(30, 31, 32);
    tick();
    idle();
    repeat (6) tick();
    check_issued("t5_order", '{17, 16, 18, 19});

    // 6: flush with entries and an issue pending; enqueue in flush cycle dropped
    for (int k = 0; k < 4; k++) begin
      do_enq(20 + k, 40 + k, 0, 0, 1);
      tick();
    end
    idle();
    wake(40, -1, -1);
    tick();
    idle();
    flush = 1'b1;
    do_enq(25, 1, 1, 0, 1);
    tick();
    idle();
    check("t6_no_issue", 32'(issue_valid), 32'd0);
    check("t6_ready", 32'(enq_ready), 32'd1);
    check("t6_data_held", 32'(issue_data), 32'h08813);
    issued.delete();
    wake(41, 42, 43);
    tick();
    idle();
    repeat (4) tick();
    check("t6_nothing", 32'(issued.size()), 32'd0);
    do_enq(24, 2, 1, 0, 1);
    tick();
    idle();
    tick();
    check("t6_new_valid", 32'(issue_valid), 32'd1);
    check("t6_new_data", 32'(issue_data), 32'h00098);
    tick();

    // Reset mid-operation zeroes the held issue word
    do_enq(5, 6, 0, 0, 1);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("rst_mid_data", 32'(issue_data), 32'd0);
    check("rst_mid_ready", 32'(enq_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
